stream_fifo: RTL and testbench
==============================

Name: stream_fifo

Overview:
- Parametrised successor to the single-entry-preload FIFO used between the exponent and normaliser stages of the softmax datapath.
- Adds:
  - configurable preload depth and value
  - non-power-of-two depth with explicit pointer wrap
  - selectable read mode: registered or first-word-fall-through
  - level output and programmable almost-full/almost-empty flags
- Buffers exp() partial results and reciprocal seeds between pipeline stages.

Parameters:
- DW, 16: data width in bits.
- N, 32: depth in entries; N >= 2, power of two not required.
- PRELOAD_N, 1: entries holding INIT_VALUE after reset; 0 <= PRELOAD_N <= N.
- INIT_VALUE, 16'h0005: value written to preloaded entries; truncated/zero-extended to DW.
- FWFT, 0: 0 = registered read; 1 = first-word-fall-through.
- AF_THRESH, N-2: almost_full asserted when level >= AF_THRESH.
- AE_THRESH, 2: almost_empty asserted when level <= AE_THRESH.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- wr_en  in  1  write request
- wr_data  in  DW  write data
- rd_en  in  1  read request (FWFT=1: pop)
- rd_data  out  DW  read data
- rd_valid  out  1  rd_data valid
- full  out  1  level == N
- empty  out  1  level == 0
- almost_full  out  1  level >= AF_THRESH
- almost_empty  out  1  level <= AE_THRESH
- level  out  $clog2(N+1)  current occupancy

Behaviour:
- Interface (already decided): reset rst, synchronous, active-high; clock clk.
- Reset, taking effect at the clock edge:
  - mem[0..PRELOAD_N-1] <= INIT_VALUE; other entries unchanged.
  - rd_ptr <= 0; wr_ptr <= PRELOAD_N mod N; level <= PRELOAD_N.
  - FWFT=0: rd_data <= 0, rd_valid <= 0.
  - Flags follow level immediately after reset. Example: PRELOAD_N=1 gives empty=0, full=(N==1, illegal), almost_empty=1 with the default AE_THRESH.
- Reset mid-operation discards all contents and in-flight reads; the next cycle reflects the preload state only.
- Write acceptance: wr_ok = wr_en & ~full, where full is the registered state at the clock edge.
  - mem[wr_ptr] <= wr_data; wr_ptr advances.
  - Every accepted write stores data. Slot 0 is NOT protected; the preload is consumed like normal data.
- Read acceptance: rd_ok = rd_en & ~empty.
- Pointer wrap: ptr == N-1 -> 0, else ptr + 1. Explicit compare, no reliance on natural overflow.
- Level update:
  - wr_ok & rd_ok: unchanged.
  - wr_ok only: +1.
  - rd_ok only: -1.
  - Never exceeds N, never below 0.
- Simultaneous events:
  - Full with wr_en & rd_en: read accepted, write rejected, level becomes N-1.
  - Empty with wr_en & rd_en: write accepted, read rejected, level becomes 1. There is no bypass.
- FWFT=0:
  - rd_ok registers mem[rd_ptr] into rd_data.
  - rd_valid is a 1-cycle pulse on the cycle after rd_ok.
  - rd_data holds its last value otherwise.
  - Latency: rd_en to data is 1 cycle.
- FWFT=1:
  - rd_data = mem[rd_ptr] combinationally; rd_valid = ~empty.
  - rd_en acts as a pop acknowledge.
  - A write to an empty FIFO appears at rd_data 1 cycle after the write edge.
- Ignored requests: rd_en while empty and wr_en while full are no-ops apart from the optional error logging below.
- All flags are combinational decodes of registered level. They are glitch-free relative to clk.

Optional Feature:
- Macro: STREAM_FIFO_ERR_FLAGS_EN.
- Defined:
  - Adds outputs overflow_err and underflow_err, 1 bit each, reset 0.
  - overflow_err sets sticky on wr_en & full.
  - underflow_err sets sticky on rd_en & empty.
  - Cleared only by rst.
- Undefined:
  - Ports absent; no extra logic.
  - Ignored requests are silent no-ops.

Decomposition:
- Package fifo_pkg:
  - function ptr_next(ptr, N) for wrap.
  - function clog2_level(N) for level width.
  - Default INIT_VALUE constant for the softmax seed.
- Sub-module fifo_ptr:
  - Parametrised pointer register with wrap at N-1 and synchronous reset value.
  - Instantiated twice: write pointer and read pointer.

Test Plan:
1. Reset with N=32, PRELOAD_N=1, INIT_VALUE=5, FWFT=0, then rd_en for 1 cycle -> next cycle rd_data=5, rd_valid=1; then empty=1, level=0.
2. N=5 (non-power-of-two), PRELOAD_N=0: write 1..5 -> full=1, level=5; 6th write ignored; read 5 -> data 1..5 in order; repeat 3 times to exercise wrap.
3. Full FIFO with wr_en=rd_en=1 for one cycle -> level 4 (N=5), head popped, new data not stored; empty FIFO with both asserted -> level 1, rd_valid stays 0.
4. FWFT=1, PRELOAD_N=0: write 0xAB -> 1 cycle later rd_valid=1, rd_data=0xAB without rd_en; rd_en pops -> empty=1.
5. N=8, AF_THRESH=6, AE_THRESH=2: fill 0..8 -> almost_empty high at levels 0-2, almost_full high at levels 6-8; reset at level 5 -> level=PRELOAD_N next cycle.
6. With STREAM_FIFO_ERR_FLAGS_EN: rd_en on empty -> underflow_err=1 and stays set after further valid traffic; rst clears it to 0.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared helpers for the stream FIFO: pointer wrap, level width and the
// default softmax reciprocal seed used to preload the buffer.
package fifo_pkg;

   localparam logic [15:0] SOFTMAX_SEED = 16'h0005;

   // Occupancy must represent 0..n inclusive, hence n+1 values.
   function automatic int clog2_level(input int n);
      return $clog2(n + 1);
   endfunction

   // Depth may be non-power-of-two, so the wrap is an explicit compare
   // rather than relying on the pointer overflowing naturally.
   function automatic int ptr_next(input int ptr, input int n);
      return (ptr == n - 1) ? 0 : ptr + 1;
   endfunction

endpackage

// File: rtl/fifo_ptr.sv
// Circular pointer register for the stream FIFO. Advances by one on
// request and wraps from N-1 back to 0; loads RESET_VAL on synchronous rst.
module fifo_ptr
   import fifo_pkg::*;
#(
   parameter int N         = 32,
   parameter int RESET_VAL = 0,
   parameter int PW        = $clog2(N)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          advance,
   output logic [PW-1:0] ptr
);

   // Pointer state: reset value on rst, wrap-aware increment on advance.
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr <= PW'(RESET_VAL);
      end else if (advance) begin
         ptr <= PW'(ptr_next(int'(ptr), N));
      end
   end

endmodule

// File: rtl/stream_fifo.sv
// Stream FIFO between the exponent and normaliser stages of the softmax
// datapath. Supports preloaded seed entries, non-power-of-two depth,
// registered or first-word-fall-through reads, and level/threshold flags.
// Optional sticky overflow/underflow flags: define STREAM_FIFO_ERR_FLAGS_EN.
module stream_fifo
   import fifo_pkg::*;
#(
   parameter int          DW         = 16,
   parameter int          N          = 32,
   parameter int          PRELOAD_N  = 1,
   parameter logic [31:0] INIT_VALUE = 32'(SOFTMAX_SEED),
   parameter int          FWFT       = 0,
   parameter int          AF_THRESH  = N - 2,
   parameter int          AE_THRESH  = 2,
   localparam int         LW         = clog2_level(N),
   localparam int         PW         = $clog2(N)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          wr_en,
   input  logic [DW-1:0] wr_data,
   input  logic          rd_en,
   output logic [DW-1:0] rd_data,
   output logic          rd_valid,
   output logic          full,
   output logic          empty,
   output logic          almost_full,
   output logic          almost_empty,
   output logic [LW-1:0] level
`ifdef STREAM_FIFO_ERR_FLAGS_EN
   ,
   output logic          overflow_err,
   output logic          underflow_err
`endif
);

   logic [DW-1:0] mem [N];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic          wr_ok;
   logic          rd_ok;

   // Requests are qualified against the registered full/empty state, so a
   // full FIFO still accepts a read and an empty one still accepts a write.
   assign wr_ok = wr_en & ~full;
   assign rd_ok = rd_en & ~empty;

   fifo_ptr #(
      .N         (N),
      .RESET_VAL (PRELOAD_N % N),
      .PW        (PW)
   ) u_wr_ptr (
      .clk     (clk),
      .rst     (rst),
      .advance (wr_ok),
      .ptr     (wr_ptr)
   );

   fifo_ptr #(
      .N         (N),
      .RESET_VAL (0),
      .PW        (PW)
   ) u_rd_ptr (
      .clk     (clk),
      .rst     (rst),
      .advance (rd_ok),
      .ptr     (rd_ptr)
   );

   // Storage: reset seeds the first PRELOAD_N slots, accepted writes store.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < PRELOAD_N; i++) begin
            mem[i] <= DW'(INIT_VALUE);
         end
      end else if (wr_ok) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   // Occupancy: simultaneous accepted read and write leave it unchanged.
   always_ff @(posedge clk) begin
      if (rst) begin
         level <= LW'(PRELOAD_N);
      end else begin
         case ({wr_ok, rd_ok})
            2'b10:   level <= level + LW'(1);
            2'b01:   level <= level - LW'(1);
            default: level <= level;
         endcase
      end
   end

   assign full         = (level == LW'(N));
   assign empty        = (level == '0);
   assign almost_full  = (int'(level) >= AF_THRESH);
   assign almost_empty = (int'(level) <= AE_THRESH);

   generate
      if (FWFT != 0) begin : g_fwft
         assign rd_data  = mem[rd_ptr];
         assign rd_valid = ~empty;
      end else begin : g_reg
         // Registered read: data captured on an accepted read, valid pulses once.
         always_ff @(posedge clk) begin
            if (rst) begin
               rd_data  <= '0;
               rd_valid <= 1'b0;
            end else begin
               rd_valid <= rd_ok;
               if (rd_ok) begin
                  rd_data <= mem[rd_ptr];
               end
            end
         end
      end
   endgenerate

`ifdef STREAM_FIFO_ERR_FLAGS_EN
   // Sticky error flags for rejected requests, cleared only by reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         overflow_err  <= 1'b0;
         underflow_err <= 1'b0;
      end else begin
         if (wr_en & full) begin
            overflow_err <= 1'b1;
         end
         if (rd_en & empty) begin
            underflow_err <= 1'b1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_stream_fifo.sv
// Self-checking bench for stream_fifo. Four instances with different
// configurations share one clock; a queue model predicts every output.
// Builds with or without STREAM_FIFO_ERR_FLAGS_EN.
module tb_stream_fifo;

   localparam int NI = 4;
   localparam int P_N   [NI] = '{32, 5, 3, 8};
   localparam int P_PRE [NI] = '{1, 0, 0, 2};
   localparam int P_INIT[NI] = '{16'h0005, 0, 0, 16'h1234};
   localparam int P_FWFT[NI] = '{0, 0, 1, 0};
   localparam int P_AF  [NI] = '{30, 3, 2, 6};
   localparam int P_AE  [NI] = '{2, 2, 0, 2};

   logic clk = 1'b0;
   logic [NI-1:0]       rst_s;
   logic [NI-1:0]       wr_en_s;
   logic [NI-1:0]       rd_en_s;
   logic [NI-1:0][15:0] wr_data_s;
   logic [NI-1:0][15:0] rd_data_s;
   logic [NI-1:0]       rd_valid_s;
   logic [NI-1:0]       full_s;
   logic [NI-1:0]       empty_s;
   logic [NI-1:0]       af_s;
   logic [NI-1:0]       ae_s;
   logic [5:0]          lvl0;
   logic [2:0]          lvl1;
   logic [1:0]          lvl2;
   logic [3:0]          lvl3;
`ifdef STREAM_FIFO_ERR_FLAGS_EN
   logic [NI-1:0]       ovf_s;
   logic [NI-1:0]       unf_s;
`endif

   // Model state: an abstract queue per instance (ring of 256, unrelated to depth).
   logic [15:0] mq [NI][256];
   int          mhead [NI];
   int          mcnt  [NI];
   logic [15:0] m_rd_data  [NI];
   logic        m_rd_valid [NI];
   logic        m_ovf [NI];
   logic        m_unf [NI];

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   stream_fifo #(.DW(16), .N(32), .PRELOAD_N(1), .INIT_VALUE(32'h0005), .FWFT(0),
                 .AF_THRESH(30), .AE_THRESH(2)) u0 (
      .clk(clk), .rst(rst_s[0]), .wr_en(wr_en_s[0]), .wr_data(wr_data_s[0]),
      .rd_en(rd_en_s[0]), .rd_data(rd_data_s[0]), .rd_valid(rd_valid_s[0]),
      .full(full_s[0]), .empty(empty_s[0]), .almost_full(af_s[0]),
      .almost_empty(ae_s[0]), .level(lvl0)
`ifdef STREAM_FIFO_ERR_FLAGS_EN
      , .overflow_err(ovf_s[0]), .underflow_err(unf_s[0])
`endif
   );

   stream_fifo #(.DW(16), .N(5), .PRELOAD_N(0), .INIT_VALUE(32'h0), .FWFT(0),
                 .AF_THRESH(3), .AE_THRESH(2)) u1 (
      .clk(clk), .rst(rst_s[1]), .wr_en(wr_en_s[1]), .wr_data(wr_data_s[1]),
      .rd_en(rd_en_s[1]), .rd_data(rd_data_s[1]), .rd_valid(rd_valid_s[1]),
      .full(full_s[1]), .empty(empty_s[1]), .almost_full(af_s[1]),
      .almost_empty(ae_s[1]), .level(lvl1)
`ifdef STREAM_FIFO_ERR_FLAGS_EN
      , .overflow_err(ovf_s[1]), .underflow_err(unf_s[1])
`endif
   );

   stream_fifo #(.DW(16), .N(3), .PRELOAD_N(0), .INIT_VALUE(32'h0), .FWFT(1),
                 .AF_THRESH(2), .AE_THRESH(0)) u2 (
      .clk(clk), .rst(rst_s[2]), .wr_en(wr_en_s[2]), .wr_data(wr_data_s[2]),
      .rd_en(rd_en_s[2]), .rd_data(rd_data_s[2]), .rd_valid(rd_valid_s[2]),
      .full(full_s[2]), .empty(empty_s[2]), .almost_full(af_s[2]),
      .almost_empty(ae_s[2]), .level(lvl2)
`ifdef STREAM_FIFO_ERR_FLAGS_EN
      , .overflow_err(ovf_s[2]), .underflow_err(unf_s[2])
`endif
   );

   stream_fifo #(.DW(16), .N(8), .PRELOAD_N(2), .INIT_VALUE(32'h1234), .FWFT(0),
                 .AF_THRESH(6), .AE_THRESH(2)) u3 (
      .clk(clk), .rst(rst_s[3]), .wr_en(wr_en_s[3]), .wr_data(wr_data_s[3]),
      .rd_en(rd_en_s[3]), .rd_data(rd_data_s[3]), .rd_valid(rd_valid_s[3]),
      .full(full_s[3]), .empty(empty_s[3]), .almost_full(af_s[3]),
      .almost_empty(ae_s[3]), .level(lvl3)
`ifdef STREAM_FIFO_ERR_FLAGS_EN
      , .overflow_err(ovf_s[3]), .underflow_err(unf_s[3])
`endif
   );

   function automatic logic [31:0] get_level(input int id);
      case (id)
         0:       return 32'(lvl0);
         1:       return 32'(lvl1);
         2:       return 32'(lvl2);
         default: return 32'(lvl3);
      endcase
   endfunction

   task automatic cmp(input string nm, input int id, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("[TB] FAIL %s u%0d @%0t: got %0h, expected %0h", nm, id, $time, act, exp);
      end
   endtask

   // Advance the reference queue by one clock using the inputs now applied.
   task automatic model_step(input int i);
      logic is_full, is_empty, rok, wok;
      if (rst_s[i]) begin
         mhead[i] = 0;
         mcnt[i]  = P_PRE[i];
         for (int k = 0; k < P_PRE[i]; k++) mq[i][k] = 16'(P_INIT[i]);
         m_rd_data[i]  = '0;
         m_rd_valid[i] = 1'b0;
         m_ovf[i] = 1'b0;
         m_unf[i] = 1'b0;
      end else begin
         is_full  = (mcnt[i] == P_N[i]);
         is_empty = (mcnt[i] == 0);
         rok = rd_en_s[i] && !is_empty;
         wok = wr_en_s[i] && !is_full;
         if (wr_en_s[i] && is_full)  m_ovf[i] = 1'b1;
         if (rd_en_s[i] && is_empty) m_unf[i] = 1'b1;
         m_rd_valid[i] = rok;
         if (rok) begin
            m_rd_data[i] = mq[i][mhead[i]];
            mhead[i] = (mhead[i] + 1) % 256;
            mcnt[i]--;
         end
         if (wok) begin
            mq[i][(mhead[i] + mcnt[i]) % 256] = wr_data_s[i];
            mcnt[i]++;
         end
      end
   endtask

   task automatic check_output(input int i);
      logic       exp_valid;
      cmp("level", i, get_level(i), 32'(mcnt[i]));
      cmp("full", i, 32'(full_s[i]), 32'(mcnt[i] == P_N[i]));
      cmp("empty", i, 32'(empty_s[i]), 32'(mcnt[i] == 0));
      cmp("almost_full", i, 32'(af_s[i]), 32'(mcnt[i] >= P_AF[i]));
      cmp("almost_empty", i, 32'(ae_s[i]), 32'(mcnt[i] <= P_AE[i]));
      exp_valid = (P_FWFT[i] != 0) ? (mcnt[i] != 0) : m_rd_valid[i];
      cmp("rd_valid", i, 32'(rd_valid_s[i]), 32'(exp_valid));
      if (P_FWFT[i] == 0) begin
         cmp("rd_data", i, 32'(rd_data_s[i]), 32'(m_rd_data[i]));
      end else if (exp_valid) begin
         cmp("rd_data_fwft", i, 32'(rd_data_s[i]), 32'(mq[i][mhead[i]]));
      end
`ifdef STREAM_FIFO_ERR_FLAGS_EN
      cmp("overflow_err", i, 32'(ovf_s[i]), 32'(m_ovf[i]));
      cmp("underflow_err", i, 32'(unf_s[i]), 32'(m_unf[i]));
`endif
   endtask

   // One clock: update model, take the edge, then compare every instance.
   task automatic tick();
      for (int i = 0; i < NI; i++) model_step(i);
      @(posedge clk);
      #1;
      for (int i = 0; i < NI; i++) check_output(i);
   endtask

   // Drive one instance for one cycle with all others idle.
   task automatic apply_stimulus(input int id, input logic r, input logic w,
                                 input logic [15:0] d, input logic rd);
      rst_s     = '0;
      wr_en_s   = '0;
      rd_en_s   = '0;
      wr_data_s = '0;
      rst_s[id]     = r;
      wr_en_s[id]   = w;
      wr_data_s[id] = d;
      rd_en_s[id]   = rd;
      tick();
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected $finish");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      logic [15:0] base;
      rst_s = '1; wr_en_s = '0; rd_en_s = '0; wr_data_s = '0;
      #2;
      tick();
      cmp("lit_reset_level", 0, get_level(0), 32'd1);
      cmp("lit_reset_empty", 0, 32'(empty_s[0]), 32'd0);
      cmp("lit_reset_ae", 0, 32'(ae_s[0]), 32'd1);
      cmp("lit_reset_rd_valid", 0, 32'(rd_valid_s[0]), 32'd0);

      // Preloaded seed comes out one cycle after the read request.
      apply_stimulus(0, 0, 0, 16'h0, 1);
      cmp("lit_preload_data", 0, 32'(rd_data_s[0]), 32'h5);
      cmp("lit_preload_valid", 0, 32'(rd_valid_s[0]), 32'd1);
      cmp("lit_after_pop_empty", 0, 32'(empty_s[0]), 32'd1);
      cmp("lit_after_pop_level", 0, get_level(0), 32'd0);
      apply_stimulus(0, 0, 0, 16'h0, 1);
      cmp("lit_underflow_no_valid", 0, 32'(rd_valid_s[0]), 32'd0);
      for (int k = 0; k < 20; k++) apply_stimulus(0, 0, k < 14, 16'(16'h300 + k), k % 3 != 0);

      // Depth 5: fill, overfill, drain in order, three rounds to wrap.
      for (int r = 0; r < 3; r++) begin
         base = 16'(16'h10 * (r + 1));
         for (int k = 1; k <= 5; k++) apply_stimulus(1, 0, 1, base + 16'(k), 0);
         cmp("lit_n5_full", 1, 32'(full_s[1]), 32'd1);
         cmp("lit_n5_level", 1, get_level(1), 32'd5);
         apply_stimulus(1, 0, 1, 16'h0099, 0);
         cmp("lit_n5_overwrite_level", 1, get_level(1), 32'd5);
         for (int k = 1; k <= 5; k++) begin
            apply_stimulus(1, 0, 0, 16'h0, 1);
            cmp("lit_n5_order", 1, 32'(rd_data_s[1]), 32'(base + 16'(k)));
         end
      end

      // Full with both requests: read wins, write dropped.
      for (int k = 1; k <= 5; k++) apply_stimulus(1, 0, 1, 16'(16'h40 + k), 0);
      apply_stimulus(1, 0, 1, 16'h0077, 1);
      cmp("lit_full_both_level", 1, get_level(1), 32'd4);
      cmp("lit_full_both_data", 1, 32'(rd_data_s[1]), 32'h41);
      for (int k = 0; k < 4; k++) apply_stimulus(1, 0, 0, 16'h0, 1);
      cmp("lit_full_both_last", 1, 32'(rd_data_s[1]), 32'h45);
      // Empty with both requests: write wins, no bypass.
      apply_stimulus(1, 0, 1, 16'h0055, 1);
      cmp("lit_empty_both_level", 1, get_level(1), 32'd1);
      cmp("lit_empty_both_valid", 1, 32'(rd_valid_s[1]), 32'd0);
      apply_stimulus(1, 0, 1, 16'h0056, 1);
      // Reset during an in-flight read discards it.
      apply_stimulus(1, 1, 0, 16'h0, 1);
      cmp("lit_midreset_valid", 1, 32'(rd_valid_s[1]), 32'd0);
      cmp("lit_midreset_level", 1, get_level(1), 32'd0);

      // First-word-fall-through on depth 3.
      apply_stimulus(2, 0, 1, 16'h00AB, 0);
      cmp("lit_fwft_valid", 2, 32'(rd_valid_s[2]), 32'd1);
      cmp("lit_fwft_data", 2, 32'(rd_data_s[2]), 32'hAB);
      apply_stimulus(2, 0, 0, 16'h0, 0);
      cmp("lit_fwft_hold", 2, 32'(rd_data_s[2]), 32'hAB);
      apply_stimulus(2, 0, 0, 16'h0, 1);
      cmp("lit_fwft_pop_empty", 2, 32'(empty_s[2]), 32'd1);
      for (int k = 0; k < 16; k++) apply_stimulus(2, 0, k % 3 != 2, 16'(16'hA0 + k), k % 2 == 1);

      // Depth 8 thresholds: drain the two seeds, then fill one by one.
      apply_stimulus(3, 0, 0, 16'h0, 1);
      cmp("lit_n8_seed", 3, 32'(rd_data_s[3]), 32'h1234);
      apply_stimulus(3, 0, 0, 16'h0, 1);
      cmp("lit_n8_ae_at0", 3, 32'(ae_s[3]), 32'd1);
      cmp("lit_n8_af_at0", 3, 32'(af_s[3]), 32'd0);
      for (int l = 1; l <= 8; l++) begin
         apply_stimulus(3, 0, 1, 16'(l), 0);
         cmp("lit_n8_ae", 3, 32'(ae_s[3]), 32'(l <= 2));
         cmp("lit_n8_af", 3, 32'(af_s[3]), 32'(l >= 6));
      end
      apply_stimulus(3, 0, 1, 16'h00EE, 0);
      cmp("lit_n8_full_level", 3, get_level(3), 32'd8);
      for (int k = 0; k < 3; k++) apply_stimulus(3, 0, 0, 16'h0, 1);
      cmp("lit_n8_level5", 3, get_level(3), 32'd5);
      apply_stimulus(3, 1, 0, 16'h0, 0);
      cmp("lit_n8_reset_level", 3, get_level(3), 32'd2);
      cmp("lit_n8_reset_data", 3, 32'(rd_data_s[3]), 32'h0);

`ifdef STREAM_FIFO_ERR_FLAGS_EN
      apply_stimulus(1, 1, 0, 16'h0, 0);
      apply_stimulus(1, 0, 0, 16'h0, 1);
      cmp("lit_unf_set", 1, 32'(unf_s[1]), 32'd1);
      for (int k = 0; k < 4; k++) apply_stimulus(1, 0, k < 2, 16'(k), k >= 2);
      cmp("lit_unf_sticky", 1, 32'(unf_s[1]), 32'd1);
      apply_stimulus(1, 1, 0, 16'h0, 0);
      cmp("lit_unf_cleared", 1, 32'(unf_s[1]), 32'd0);
`endif

      apply_stimulus(0, 0, 0, 16'h0, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
